// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets four requesters share one UART
// transmitter. Ownership is granted per whole message. Each byte is handed to
// the UART with an XMitGo/TxEmpty handshake. A transmitter that never
// acknowledges a byte causes the message to be abandoned with a TimeoutErr pulse.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Req,
  input  logic [3:0]  Last,
  input  logic [31:0] Data,
  output logic [3:0]  Ack,
  output logic [3:0]  Grant,
  input  logic        TxEmpty,
  output logic        XMitGo,
  output logic [7:0]  TxData,
  output logic        Busy,
  output logic        TimeoutErr
);

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  gidx;
  logic [15:0] tcnt;
  logic        last_byte;

  logic [1:0]  winner;
  logic [15:0] tcnt_nxt;
  logic [7:0]  gbyte;

  // First requester at or above the rotating pointer, wrapping modulo 4.
  // The loop runs from the farthest slot down, so the nearest set bit wins.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] w;
    logic [1:0] idx;
    w = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) w = idx;
    end
    return w;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Winner search, saturating timeout increment and granted byte selection.
  always_comb begin
    winner   = pick(Req, ptr);
    tcnt_nxt = (tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1;
    gbyte    = Data[{gidx, 3'b000} +: 8];
  end

  assign Busy = (state != IDLE);

  // Arbiter FSM. Ack and TimeoutErr default low, so each is a one-cycle pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      gidx       <= 2'd0;
      tcnt       <= 16'd0;
      last_byte  <= 1'b0;
      Grant      <= 4'd0;
      Ack        <= 4'd0;
      XMitGo     <= 1'b0;
      TxData     <= 8'h00;
      TimeoutErr <= 1'b0;
    end else begin
      Ack        <= 4'd0;
      TimeoutErr <= 1'b0;
      case (state)
        IDLE: begin
          Grant <= 4'd0;
          if ((|Req) && TxEmpty) begin
            gidx  <= winner;
            Grant <= onehot(winner);
            state <= LOAD;
          end
        end
        LOAD: begin
          if (Req[gidx]) begin
            TxData    <= gbyte;
            last_byte <= Last[gidx];
            XMitGo    <= 1'b1;
            Ack       <= onehot(gidx);
            tcnt      <= 16'd0;
            state     <= SEND;
          end else begin
            Grant <= 4'd0;
            ptr   <= gidx + 2'd1;
            state <= IDLE;
          end
        end
        SEND: begin
          if (!TxEmpty) begin
            XMitGo <= 1'b0;
            state  <= DRAIN;
          end else begin
            tcnt <= tcnt_nxt;
            if (tcnt_nxt >= TMO) begin
              XMitGo     <= 1'b0;
              TimeoutErr <= 1'b1;
              Grant      <= 4'd0;
              ptr        <= gidx + 2'd1;
              state      <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (TxEmpty) begin
            if (last_byte) begin
              Grant <= 4'd0;
              ptr   <= gidx + 2'd1;
              state <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Requester processes feed byte queues, and a
// UART model acknowledges bytes. A scoreboard compares every byte handed to
// the UART and every timeout pulse against expectations queued by the stimulus.
module tb_uart_tx_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [3:0]  Req;
  logic [3:0]  Last;
  logic [31:0] Data;
  logic [3:0]  Ack;
  logic [3:0]  Grant;
  logic        TxEmpty;
  logic        XMitGo;
  logic [7:0]  TxData;
  logic        Busy;
  logic        TimeoutErr;

  logic uart_mode;
  logic uart_empty;
  logic tb_empty;
  assign TxEmpty = uart_mode ? uart_empty : tb_empty;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
  } tx_t;

  tx_t        exp_q[$];
  int         exp_tmo;
  logic [8:0] rq[4][$];
  int         ack_seen[4];
  int         n_checks;
  int         n_pass;

  uart_tx_arbiter #(.TIMEOUT_CYC(16)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Req(Req),
    .Last(Last),
    .Data(Data),
    .Ack(Ack),
    .Grant(Grant),
    .TxEmpty(TxEmpty),
    .XMitGo(XMitGo),
    .TxData(TxData),
    .Busy(Busy),
    .TimeoutErr(TimeoutErr)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic bit rq_pending();
    return (rq[0].size() != 0) || (rq[1].size() != 0) || (rq[2].size() != 0) || (rq[3].size() != 0);
  endfunction

  // Requesters: present the head of each queue and pop it on Ack.
  initial begin
    Req = 4'd0; Last = 4'd0; Data = 32'd0;
    forever begin
      @(posedge Clock); #1;
      for (int i = 0; i < 4; i++) begin
        if (Ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        Req[i] = (rq[i].size() != 0);
        if (rq[i].size() != 0) begin
          Data[8*i +: 8] = rq[i][0][7:0];
          Last[i]        = rq[i][0][8];
        end
      end
    end
  end

  // UART model: busy 2 cycles after XMitGo is seen, holding busy for 10 cycles.
  initial begin
    uart_empty = 1'b1;
    forever begin
      @(posedge Clock); #1;
      if (uart_mode && XMitGo && uart_empty) begin
        @(posedge Clock); #1;
        uart_empty = 1'b0;
        repeat (10) @(posedge Clock);
        #1;
        uart_empty = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic       xprev;
    logic [3:0] aprev;
    tx_t        e;
    xprev = 1'b0;
    aprev = 4'd0;
    forever begin
      @(negedge Clock);
      check("grant_onehot0", 32'($onehot0(Grant)), 32'd1);
      check("ack_onehot0", 32'($onehot0(Ack)), 32'd1);
      if (aprev != 4'd0) check("ack_one_cycle", 32'(Ack), 32'd0);
      for (int i = 0; i < 4; i++) if (Ack[i] && !aprev[i]) ack_seen[i]++;
      if (XMitGo && !xprev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected: grant %b data %h, no byte expected", Grant, TxData);
        end else begin
          e = exp_q.pop_front();
          check("tx_grant", 32'(Grant), 32'(e.g));
          check("tx_data", 32'(TxData), 32'(e.d));
          check("tx_ack", 32'(Ack), 32'(e.g));
        end
      end
      if (TimeoutErr) begin
        if (exp_tmo == 0) begin
          n_checks++;
          $display("FAIL tmo_unexpected: TimeoutErr 1, required 0");
        end else begin
          exp_tmo--;
          check("tmo_grant_clear", 32'(Grant), 32'd0);
        end
      end
      xprev = XMitGo;
      aprev = Ack;
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) rq[i].delete();
    @(negedge Clock);
    check("rst_grant", 32'(Grant), 32'd0);
    check("rst_xmitgo", 32'(XMitGo), 32'd0);
    check("rst_txdata", 32'(TxData), 32'd0);
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_tmo", 32'(TimeoutErr), 32'd0);
    Reset = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_tmo != 0 || rq_pending() || Busy) && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    int bad;
    int base;
    Reset = 1'b1;
    uart_mode = 1'b1;
    tb_empty = 1'b1;
    exp_tmo = 0;
    n_checks = 0;
    n_pass = 0;
    for (int i = 0; i < 4; i++) ack_seen[i] = 0;
    do_reset();

    // Three-byte message from requester 0.
    rq[0].push_back({1'b0, 8'h41});
    rq[0].push_back({1'b0, 8'h42});
    rq[0].push_back({1'b1, 8'h43});
    exp_q.push_back('{g: 4'b0001, d: 8'h41});
    exp_q.push_back('{g: 4'b0001, d: 8'h42});
    exp_q.push_back('{g: 4'b0001, d: 8'h43});
    wait_done("msg3_done", 300);
    check("msg3_busy_after", 32'(Busy), 32'd0);
    check("msg3_acks", 32'(ack_seen[0]), 32'd3);

    // Two requesters posting single-byte messages alternate.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rq[0].push_back({1'b1, 8'hA0 + 8'(k)});
      rq[1].push_back({1'b1, 8'hB0 + 8'(k)});
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{g: 4'b0001, d: 8'hA0 + 8'(k)});
      exp_q.push_back('{g: 4'b0010, d: 8'hB0 + 8'(k)});
    end
    wait_done("rr_done", 600);

    // Timeout with TxEmpty stuck high, then pending requester 3 is served.
    do_reset();
    uart_mode = 1'b0;
    tb_empty = 1'b1;
    rq[2].push_back({1'b0, 8'h55});
    rq[2].push_back({1'b1, 8'h56});
    rq[3].push_back({1'b1, 8'h77});
    exp_q.push_back('{g: 4'b0100, d: 8'h55});
    exp_tmo = 1;
    n = 0;
    while (!XMitGo && n < 50) begin @(negedge Clock); n++; end
    check("tmo_xmit_started", 32'(XMitGo), 32'd1);
    hi = 0;
    while (XMitGo && hi < 100) begin @(negedge Clock); hi++; end
    check("tmo_xmit_len", 32'(hi), 32'd16);
    check("tmo_err", 32'(TimeoutErr), 32'd1);
    check("tmo_grant", 32'(Grant), 32'd0);
    uart_mode = 1'b1;
    exp_q.push_back('{g: 4'b1000, d: 8'h77});
    exp_q.push_back('{g: 4'b0100, d: 8'h56});
    wait_done("tmo_done", 400);

    // Reset during DRAIN of requester 3's second byte drops the message.
    rq[3].push_back({1'b0, 8'h31});
    rq[3].push_back({1'b0, 8'h32});
    rq[3].push_back({1'b1, 8'h33});
    exp_q.push_back('{g: 4'b1000, d: 8'h31});
    exp_q.push_back('{g: 4'b1000, d: 8'h32});
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge Clock); n++; end
    check("drain_reached_byte2", 32'(exp_q.size()), 32'd0);
    n = 0;
    while (XMitGo && n < 20) begin @(negedge Clock); n++; end
    check("drain_state", 32'(Busy && !XMitGo), 32'd1);
    do_reset();
    rq[3].push_back({1'b1, 8'h39});
    rq[0].push_back({1'b1, 8'h09});
    exp_q.push_back('{g: 4'b0001, d: 8'h09});
    exp_q.push_back('{g: 4'b1000, d: 8'h39});
    wait_done("post_rst_done", 400);

    // Requester 1 withdraws after its first (non-final) byte.
    base = ack_seen[1];
    rq[1].push_back({1'b0, 8'h61});
    exp_q.push_back('{g: 4'b0010, d: 8'h61});
    wait_done("wd_done", 300);
    check("wd_acks", 32'(ack_seen[1] - base), 32'd1);
    check("wd_grant", 32'(Grant), 32'd0);
    check("wd_xmitgo", 32'(XMitGo), 32'd0);

    // No grant while the UART reports busy.
    uart_mode = 1'b0;
    tb_empty = 1'b0;
    rq[0].push_back({1'b1, 8'h35});
    bad = 0;
    repeat (20) begin
      @(negedge Clock);
      if (Grant != 4'd0) bad++;
    end
    check("busy_uart_no_grant", 32'(bad), 32'd0);
    tb_empty = 1'b1;
    @(negedge Clock);
    check("empty_grant", 32'(Grant), 32'd1);
    uart_mode = 1'b1;
    exp_q.push_back('{g: 4'b0001, d: 8'h35});
    wait_done("empty_done", 300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 65535, max cycles XMitGo may stay high before the UART acknowledges (TxEmpty low); range 1..65535.
REQ-002 Clock  input  1  system clock; all logic on rising edge.
REQ-003 Reset  input  1  synchronous, active-high.
REQ-004 Req  input  4  per-requester "byte valid / message in progress", bit i = requester i.
REQ-005 Last  input  4  bit i high: byte presented by requester i is the final byte of its message.
REQ-006 Data  input  32  requester i byte on bits 8i+7:8i.
REQ-007 Ack  output  4  one-cycle pulse on bit i: byte of requester i taken.
REQ-008 Grant  output  4  one-hot owner of the UART; 0 when idle.
REQ-009 TxEmpty  input  1  UART transmitter ready (high) / busy (low).
REQ-010 XMitGo  output  1  UART transmit request, registered.
REQ-011 TxData  output  8  byte to UART, registered, stable while XMitGo high.
REQ-012 Busy  output  1  high in every state except IDLE.
REQ-013 TimeoutErr  output  1  one-cycle pulse on UART acknowledge timeout.

Function
REQ-014 FSM states: IDLE, LOAD, SEND, DRAIN; arbitration granularity is one whole message.
REQ-015 IDLE: Grant=0; if any Req bit high and TxEmpty=1, winner = first set Req bit searching from Ptr upward mod 4; Grant <= onehot(winner); -> LOAD.
REQ-016 IDLE with TxEmpty=0: no grant, stay IDLE regardless of Req.
REQ-017 LOAD, Req[g] high: TxData <= Data[g slice], LastByte <= Last[g], XMitGo <= 1, Ack[g] <= 1 for exactly one cycle, timeout counter <= 0; -> SEND.
REQ-018 LOAD, Req[g] low (withdrawal): no Ack, XMitGo stays 0, Grant <= 0, Ptr <= g+1 mod 4; -> IDLE.
REQ-019 Latency: Req sampled in IDLE at edge N -> Grant high after N; XMitGo, TxData, Ack valid after N+1.
REQ-020 SEND: hold XMitGo=1 and TxData; when TxEmpty=0, XMitGo <= 0; -> DRAIN.
REQ-021 SEND: counter increments each cycle TxEmpty=1; on reaching TIMEOUT_CYC: XMitGo <= 0, TimeoutErr one-cycle pulse, Grant <= 0, Ptr <= g+1 mod 4; -> IDLE (message abandoned).
REQ-022 DRAIN: wait TxEmpty=1; then if LastByte: Grant <= 0, Ptr <= g+1 mod 4, -> IDLE; else -> LOAD (same owner).
REQ-023 Requester updates Data/Last after its Ack pulse; arbiter samples them no earlier than the next LOAD (>= 3 cycles after Ack).
REQ-024 Changes on non-granted Req/Data/Last bits never affect an in-progress message.
REQ-025 Req[g] dropping during SEND/DRAIN does not abort the current byte; checked only at next LOAD.
REQ-026 Ptr is 2 bits, wraps 3 -> 0; exactly one Ack bit or none high per cycle; Grant always one-hot or zero.
REQ-027 Timeout counter 16 bits, saturates, never wraps.

Reset
REQ-028 Reset high at any edge, any state: next cycle state IDLE, XMitGo=0, TxData=8'h00, Grant=0, Ack=0, Busy=0, TimeoutErr=0, Ptr=0, counter=0, LastByte=0.
REQ-029 Reset dominates all inputs; a message interrupted by Reset is dropped, not resumed.

Verification
REQ-030 Req[0]=1, bytes 41,42,43 with Last on 43; UART model drops TxEmpty 2 cycles after XMitGo, holds low 10 -> TxData 41,42,43 in order, three Ack[0] pulses, Grant=0001 throughout, Busy low after.
REQ-031 Req[0] and Req[1] continuously posting 1-byte messages after reset -> grants alternate 0001,0010,0001,0010; no back-to-back grant to the same requester.
REQ-032 TIMEOUT_CYC=16, TxEmpty held high, Req[2]=1 -> XMitGo high 16 cycles then low, TimeoutErr pulses once, Grant=0, pending Req[3] granted next.
REQ-033 Reset asserted in DRAIN of byte 2 of requester 3 -> next cycle all outputs zero; after release with Req[3] and Req[0] high, Grant=0001 first.
REQ-034 Req[1] drops after Ack of byte 1 (Last=0) -> no second Ack, XMitGo stays 0, Grant returns 0 after LOAD.
REQ-035 Req[0]=1 with TxEmpty=0 for 20 cycles -> Grant stays 0 until TxEmpty=1, then Grant=0001 next cycle.
